// File: rtl/sap_pkg.sv
// Shared constants and types for the SAP-1 controller-sequencer:
// opcodes, one-hot T-state encodings and the packed control word.
package sap_pkg;

  // Opcodes carried in the IR upper nibble
  localparam logic [3:0] OP_LDA = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  // One-hot T-states, bit0 = T1
  localparam logic [5:0] T1 = 6'b000001;
  localparam logic [5:0] T2 = 6'b000010;
  localparam logic [5:0] T3 = 6'b000100;
  localparam logic [5:0] T4 = 6'b001000;
  localparam logic [5:0] T5 = 6'b010000;
  localparam logic [5:0] T6 = 6'b100000;

  // Control word, fields in port order (first field is the MSB)
  typedef struct packed {
    logic pc_en;
    logic pc_inc;
    logic mar_load;
    logic ram_en;
    logic ir_load;
    logic ir_en;
    logic load_a;
    logic enable_a;
    logic load_b;
    logic enable_b;
    logic add;
    logic sub;
    logic alu_en;
    logic out_load;
  } ctrl_word_t;

  // True for opcodes the base ISA defines; anything else executes as a NOP
  function automatic logic is_defined_op(input logic [3:0] op);
    return (op == OP_LDA) || (op == OP_ADD) || (op == OP_SUB) ||
           (op == OP_OUT) || (op == OP_HLT);
  endfunction

endpackage

// File: rtl/sap_controller_if.sv
// Control bus between the SAP-1 controller (master) and the datapath (slave):
// run/opcode flow into the controller, strobes/halt/t_state flow out.
interface sap_controller_if #(
  parameter int OPW = 4,
  parameter int NT  = 6
);
  logic           run;
  logic [OPW-1:0] opcode;
  logic           pc_en;
  logic           pc_inc;
  logic           mar_load;
  logic           ram_en;
  logic           ir_load;
  logic           ir_en;
  logic           load_a;
  logic           enable_a;
  logic           load_b;
  logic           enable_b;
  logic           add;
  logic           sub;
  logic           alu_en;
  logic           out_load;
  logic           halt;
  logic [NT-1:0]  t_state;

  modport master (
    input  run, opcode,
    output pc_en, pc_inc, mar_load, ram_en, ir_load, ir_en, load_a, enable_a,
           load_b, enable_b, add, sub, alu_en, out_load, halt, t_state
  );

  modport slave (
    output run, opcode,
    input  pc_en, pc_inc, mar_load, ram_en, ir_load, ir_en, load_a, enable_a,
           load_b, enable_b, add, sub, alu_en, out_load, halt, t_state
  );
endinterface

// File: rtl/sap_ring_counter.sv
// NT-bit one-hot T-state ring counter with hold, early wrap to T1 and
// synchronous active-low reset to T1.
module sap_ring_counter #(
  parameter int NT = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          advance,
  input  logic          early_wrap,
  output logic [NT-1:0] t_state
);
  localparam logic [NT-1:0] FIRST = NT'(1);

  logic [NT-1:0] state_reg;
  logic [NT-1:0] state_next;
  logic [NT-1:0] shifted;

  // One-position rotate without the wrap bit; the wrap is handled explicitly
  assign shifted[0] = 1'b0;
  genvar gi;
  generate
    for (gi = 1; gi < NT; gi++) begin : g_shift
      assign shifted[gi] = state_reg[gi-1];
    end
  endgenerate

  // Next state: hold, step, or return to T1 from the last or an early state
  always_comb begin
    state_next = state_reg;
    if (advance) begin
      if (early_wrap || state_reg[NT-1]) state_next = FIRST;
      else                               state_next = shifted;
    end
  end

  // State register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) state_reg <= FIRST;
    else      state_reg <= state_next;
  end

  assign t_state = state_reg;
endmodule

// File: rtl/sap_controller.sv
// SAP-1 controller-sequencer: steps T1..T6, decodes the IR opcode into
// per-T-state bus strobes and holds a sticky halt flag.
// Optional macro SAP_CTRL_EARLY_FETCH_EN: instructions whose remaining
// T-states are empty return to T1 early (LDA after T5, OUT after T4,
// undefined opcodes after T3).
module sap_controller
  import sap_pkg::*;
#(
  parameter int OPW = 4,
  parameter int NT  = 6
) (
  input  logic            clk,
  input  logic            rst,
  sap_controller_if.master bus
);
  logic [OPW-1:0] opcode;
  logic [NT-1:0]  t_state;
  logic           halt_reg;
  logic           halt_next;
  logic           gate;
  logic           hlt_fire;
  logic           advance;
  logic           early_wrap;
  ctrl_word_t     ctrl;

  assign opcode = bus.opcode;

  // State register: halt flag here, T-state inside the ring counter
  always_ff @(posedge clk) begin
    if (!rst) halt_reg <= 1'b0;
    else      halt_reg <= halt_next;
  end

  sap_ring_counter #(.NT(NT)) u_ring (
    .clk       (clk),
    .rst       (rst),
    .advance   (advance),
    .early_wrap(early_wrap),
    .t_state   (t_state)
  );

  // Next-state logic: HLT at T4 sets halt and freezes the counter on the same edge
  always_comb begin
    gate      = bus.run & ~halt_reg & rst;
    hlt_fire  = gate && (t_state == T4) && (opcode == OP_HLT);
    advance   = gate & ~hlt_fire;
    halt_next = halt_reg | hlt_fire;
`ifdef SAP_CTRL_EARLY_FETCH_EN
    early_wrap = ((t_state == T5) && (opcode == OP_LDA)) ||
                 ((t_state == T4) && (opcode == OP_OUT)) ||
                 ((t_state == T3) && !is_defined_op(opcode));
`else
    early_wrap = 1'b0;
`endif
  end

  // Output decode: Moore strobes from (t_state, opcode), all zero unless gated on
  always_comb begin
    ctrl = '0;
    if (gate) begin
      case (t_state)
        T1: begin ctrl.pc_en = 1'b1; ctrl.mar_load = 1'b1; end
        T2: ctrl.pc_inc = 1'b1;
        T3: begin ctrl.ram_en = 1'b1; ctrl.ir_load = 1'b1; end
        T4: begin
          if (opcode == OP_LDA || opcode == OP_ADD || opcode == OP_SUB) begin
            ctrl.ir_en = 1'b1; ctrl.mar_load = 1'b1;
          end else if (opcode == OP_OUT) begin
            ctrl.enable_a = 1'b1; ctrl.out_load = 1'b1;
          end
        end
        T5: begin
          if (opcode == OP_LDA) begin
            ctrl.ram_en = 1'b1; ctrl.load_a = 1'b1;
          end else if (opcode == OP_ADD || opcode == OP_SUB) begin
            ctrl.ram_en = 1'b1; ctrl.load_b = 1'b1;
          end
        end
        T6: begin
          if (opcode == OP_ADD || opcode == OP_SUB) begin
            ctrl.alu_en = 1'b1; ctrl.load_a = 1'b1;
            ctrl.add    = (opcode == OP_ADD);
            ctrl.sub    = (opcode == OP_SUB);
          end
        end
        default: ctrl = '0;
      endcase
    end
  end

  assign bus.pc_en    = ctrl.pc_en;
  assign bus.pc_inc   = ctrl.pc_inc;
  assign bus.mar_load = ctrl.mar_load;
  assign bus.ram_en   = ctrl.ram_en;
  assign bus.ir_load  = ctrl.ir_load;
  assign bus.ir_en    = ctrl.ir_en;
  assign bus.load_a   = ctrl.load_a;
  assign bus.enable_a = ctrl.enable_a;
  assign bus.load_b   = ctrl.load_b;
  assign bus.enable_b = ctrl.enable_b;
  assign bus.add      = ctrl.add;
  assign bus.sub      = ctrl.sub;
  assign bus.alu_en   = ctrl.alu_en;
  assign bus.out_load = ctrl.out_load;
  assign bus.halt     = halt_reg;
  assign bus.t_state  = t_state;
endmodule

// File: doc/sap_controller.md
Name: sap_controller

Overview:
- Controller-sequencer for the SAP-1 datapath. It drives the control word that the A/B registers, ALU, PC, MAR, RAM, IR and output register respond to.
- A six-state ring counter (T1..T6) steps each instruction; the IR opcode is decoded to produce per-T-state load/enable strobes.
- It is the initiating end of the register load/enable bus protocol, and it halts on HLT.

Parameters:
- OPW, 4, opcode width (IR upper nibble)
- NT, 6, T-states per instruction cycle

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-low reset
- run  in  1  1 = sequence advances; 0 = hold current T-state, all strobes forced 0
- opcode  in  OPW  IR opcode, valid from T4 onward
- pc_en  out  1  PC drives bus
- pc_inc  out  1  PC increment
- mar_load  out  1  MAR loads from bus
- ram_en  out  1  RAM drives bus
- ir_load  out  1  IR loads from bus
- ir_en  out  1  IR address nibble drives bus
- load_a  out  1  A register load
- enable_a  out  1  A register drives bus
- load_b  out  1  B register load
- enable_b  out  1  B register drives bus (always 0 in base ISA)
- add  out  1  ALU add select
- sub  out  1  ALU subtract select
- alu_en  out  1  ALU result drives bus
- out_load  out  1  output register load
- halt  out  1  sticky halt flag
- t_state  out  NT  one-hot current T-state (bit0 = T1)

Behaviour:
- Reset: rst==0 at a clk edge sets t_state=6'b000001 and clears halt. While rst==0, all strobes are combinationally forced to 0.
- Ring counter advances one state per clk when run=1, rst=1 and halt=0. T6 wraps to T1.
- Strobes are a combinational Moore decode of (t_state, opcode), gated by run & ~halt & rst. All strobes are 0 unless listed:
  - T1: pc_en, mar_load
  - T2: pc_inc
  - T3: ram_en, ir_load
- LDA 4'b0000:
  - T4: ir_en, mar_load
  - T5: ram_en, load_a
  - T6: none
- ADD 4'b0001:
  - T4: ir_en, mar_load
  - T5: ram_en, load_b
  - T6: alu_en, add, load_a
- SUB 4'b0010: as ADD, but T6 asserts sub instead of add.
- OUT 4'b1110:
  - T4: enable_a, out_load
  - T5-T6: none
- HLT 4'b1111: at T4, halt is set on the clk edge. The counter freezes at T4 and all strobes are 0 from the following cycle. Only reset clears halt.
- Undefined opcodes: NOP, with no strobes in T4-T6.
- Bus exclusivity: at most one of pc_en, ram_en, ir_en, enable_a, enable_b, alu_en is 1 in any cycle.
- add and sub are never both 1.
- run deasserted mid-instruction: the state is held, and on reassertion the sequence resumes in the same T-state.
- Reset mid-instruction returns to T1 regardless of T-state or halt.
- opcode changes during T1-T3 are ignored because the decode uses opcode only in T4-T6.

Optional Feature:
- Macro SAP_CTRL_EARLY_FETCH_EN.
- Defined: an instruction whose remaining T-states are empty returns to T1 early.
  - LDA: after T5, the next state is T1.
  - OUT: after T4, the next state is T1.
  - Undefined opcode: after T3, the next state is T1.
  - ADD/SUB still use T6.
- Not defined: every instruction takes the full six T-states.

Decomposition:
- Package sap_pkg holds:
  - opcode localparams OP_LDA, OP_ADD, OP_SUB, OP_OUT, OP_HLT
  - T-state one-hot constants T1..T6
  - packed struct ctrl_word_t with all strobes in port order
- Sub-module sap_ring_counter holds the NT-bit one-hot shift register with hold, synchronous reset, and an early-wrap input.
- Decode and the halt flag stay in sap_controller.

Test Plan:
- Reset and fetch: rst=0 for 2 cycles, then run=1, opcode=4'hF → T1 strobes pc_en and mar_load, T2 pc_inc, T3 ram_en and ir_load. Then halt=1 at the T4→next edge, with t_state held at 6'b001000 and all strobes 0 for 10 cycles.
- ADD sequence: opcode=4'h1 → T4 ir_en and mar_load, T5 ram_en and load_b, T6 alu_en, add and load_a. Then t_state wraps to 6'b000001.
- SUB and OUT: opcode=4'h2 → T6 sub=1 and add=0. opcode=4'hE → T4 enable_a and out_load, T5-T6 all strobes 0 (six-state cycle without macro).
- Run hold: deassert run during T5 of LDA for 3 cycles → t_state stays 6'b010000 with strobes 0. On reassertion, ram_en and load_a are asserted.
- Reset mid-flight: rst=0 during T5 of ADD, and separately while halted → next state T1 with halt=0.
- Bus check (all tests): an assertion that at most one bus driver is active, plus a cycle-count check with SAP_CTRL_EARLY_FETCH_EN defined: LDA = 5 cycles, OUT = 4, ADD = 6.
